// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and encodings for the pipeline hazard controller
package pipe_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipe_fwd.sv
// rtl/pipe_fwd.sv - operand forwarding select for one execute-stage source
module pipe_fwd
    import pipe_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic       reg_write_m,
    input  logic [4:0] rd_m,
    input  logic       reg_write_w,
    input  logic [4:0] rd_w,
    output logic [1:0] fwd
);

    // Memory stage holds the newer value, so it wins over writeback; x0 is never forwarded
    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard unit: forwarding, load-use/branch hazards, data-memory wait with timeout
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 MemReqM,
    input  logic                 MemReady,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic                 MemErr
);

    localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TIMEOUT_V = WW'(MEM_TIMEOUT);

    state_t         state;
    state_t         state_n;
    logic [WW-1:0]  wait_cnt;
    logic           timeout_hit;
    logic           mem_stall;
    logic           lw_stall;
    logic           any_stall;
    logic [1:0]     fwd_a;
    logic [1:0]     fwd_b;

    assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == TIMEOUT_V);
    assign mem_stall   = MemReqM && !MemReady && !timeout_hit;
    assign lw_stall    = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign any_stall   = StallF || StallD || StallE || StallM;

    pipe_fwd u_fwd_a (
        .rs_e        (Rs1E),
        .reg_write_m (RegWriteM),
        .rd_m        (RdM),
        .reg_write_w (RegWriteW),
        .rd_w        (RdW),
        .fwd         (fwd_a)
    );

    pipe_fwd u_fwd_b (
        .rs_e        (Rs2E),
        .reg_write_m (RegWriteM),
        .rd_m        (RdM),
        .reg_write_w (RegWriteW),
        .rd_w        (RdW),
        .fwd         (fwd_b)
    );

    // Forward selects read as register-file during reset so nothing stale leaks into execute
    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: wait out an unacknowledged access, abandon it on timeout
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (MemReqM && !MemReady) state_n = MEM_WAIT;
            MEM_WAIT: if (MemReady || timeout_hit) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Stall/flush outputs: memory wait freezes everything and defers load-use and branch handling
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall && !PCSrcE;
            StallD = lw_stall && !PCSrcE;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
        end
    end

    // Wait counter restarts whenever idle so it is zero on the first MEM_WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MemErr <= 1'b0;
        end else if (timeout_hit) begin
            MemErr <= 1'b1;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCnt <= '0;
        end else if (any_stall && (StallCnt != {CNT_WIDTH{1'b1}})) begin
            StallCnt <= StallCnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReady;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCnt;
    logic        MemErr;

    typedef struct {
        logic [3:0]  st;
        logic [2:0]  fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          step_no  = 0;
    logic [31:0] exp_cnt  = 32'd0;
    logic        exp_err  = 1'b0;

    pipe_ctrl #(.MEM_TIMEOUT(8), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .RdM        (RdM),
        .RdW        (RdW),
        .MemReqM    (MemReqM),
        .MemReady   (MemReady),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallCnt   (StallCnt),
        .MemErr     (MemErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d got %0h expected %0h", tag, step_no, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic rwm, input logic [4:0] rdm,
                                           input logic rww, input logic [4:0] rdw,
                                           input logic [4:0] rs);
        if (rwm && rdm != 5'd0 && rdm == rs) return 2'b10;
        if (rww && rdw != 5'd0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    // st = {StallF,StallD,StallE,StallM}, fl = {FlushD,FlushE,FlushW}
    task automatic cyc(input logic [3:0] st, input logic [2:0] fl);
        exp_t e;
        exp_t o;
        e.st  = st;
        e.fl  = fl;
        e.fa  = rst ? 2'b00 : fwd_ref(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
        e.fb  = rst ? 2'b00 : fwd_ref(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
        e.cnt = exp_cnt;
        e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        check("stall", 32'({StallF, StallD, StallE, StallM}), 32'(o.st));
        check("flush", 32'({FlushD, FlushE, FlushW}), 32'(o.fl));
        check("fwd_a", 32'(ForwardAE), 32'(o.fa));
        check("fwd_b", 32'(ForwardBE), 32'(o.fb));
        check("stall_cnt", StallCnt, o.cnt);
        check("mem_err", 32'(MemErr), 32'(o.err));
        if (o.st != 4'b0000) exp_cnt = exp_cnt + 32'd1;
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        ResultSrcE = 1'b0; PCSrcE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; MemReady = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        idle_inputs();
        RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3;
        ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
        cyc(4'b0000, 3'b111);
        rst = 1'b0;
        idle_inputs();
        cyc(4'b0000, 3'b000);

        // forwarding
        RegWriteM = 1'b1; RdM = 5'd3; RegWriteW = 1'b1; RdW = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
        cyc(4'b0000, 3'b000);
        RdM = 5'd0;
        cyc(4'b0000, 3'b000);
        RdW = 5'd0;
        cyc(4'b0000, 3'b000);
        RegWriteM = 1'b0; RdM = 5'd7; RdW = 5'd7; Rs2E = 5'd7;
        cyc(4'b0000, 3'b000);
        for (int i = 0; i < 8; i++) begin
            RegWriteM = 1'($urandom_range(0, 1)); RdM = 5'($urandom_range(0, 3));
            RegWriteW = 1'($urandom_range(0, 1)); RdW = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            cyc(4'b0000, 3'b000);
        end
        idle_inputs();

        // load-use
        ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        cyc(4'b1100, 3'b010);
        ResultSrcE = 1'b0;
        cyc(4'b0000, 3'b000);
        ResultSrcE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        cyc(4'b0000, 3'b000);
        RdE = 5'd6; Rs2D = 5'd6;
        cyc(4'b1100, 3'b010);
        idle_inputs();

        // branch overrides load-use
        ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
        cyc(4'b0000, 3'b110);
        ResultSrcE = 1'b0;
        cyc(4'b0000, 3'b110);
        idle_inputs();

        // memory wait of four cycles, hazards deferred until release
        MemReqM = 1'b1; MemReady = 1'b0;
        cyc(4'b1111, 3'b001);
        cyc(4'b1111, 3'b001);
        ResultSrcE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
        cyc(4'b1111, 3'b001);
        cyc(4'b1111, 3'b001);
        MemReady = 1'b1;
        cyc(4'b0000, 3'b110);
        idle_inputs();
        cyc(4'b0000, 3'b000);
        MemReqM = 1'b1; MemReady = 1'b1;
        cyc(4'b0000, 3'b000);
        idle_inputs();

        // timeout: one IDLE stall cycle, eight MEM_WAIT stall cycles, then abort
        MemReqM = 1'b1; MemReady = 1'b0;
        for (int i = 0; i < 9; i++) cyc(4'b1111, 3'b001);
        cyc(4'b0000, 3'b000);
        MemReqM = 1'b0;
        exp_err = 1'b1;
        for (int i = 0; i < 3; i++) cyc(4'b0000, 3'b000);

        // reset during MEM_WAIT
        MemReqM = 1'b1; MemReady = 1'b0;
        cyc(4'b1111, 3'b001);
        cyc(4'b1111, 3'b001);
        rst = 1'b1;
        exp_cnt = 32'd0;
        exp_err = 1'b0;
        cyc(4'b0000, 3'b111);
        rst = 1'b0;
        MemReqM = 1'b0;
        cyc(4'b0000, 3'b000);
        MemReqM = 1'b1; MemReady = 1'b1;
        cyc(4'b0000, 3'b000);
        MemReady = 1'b0;
        cyc(4'b1111, 3'b001);
        MemReady = 1'b1;
        cyc(4'b0000, 3'b000);
        idle_inputs();
        cyc(4'b0000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before abort.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, stall-counter width.
REQ-003 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports Rs1D, Rs2D  in  5 each  decode-stage source registers.
REQ-006 SHALL have ports Rs1E, Rs2E, RdE  in  5 each  execute-stage sources and destination.
REQ-007 SHALL have port ResultSrcE  in  1  execute-stage instruction is a load.
REQ-008 SHALL have port PCSrcE  in  1  taken branch or jump resolved in execute.
REQ-009 SHALL have ports RegWriteM, RegWriteW  in  1 each; RdM, RdW  in  5 each  memory/writeback write-back info.
REQ-010 SHALL have ports MemReqM  in  1  load/store in memory stage; MemReady  in  1  data-memory acknowledge.
REQ-011 SHALL have outputs StallF, StallD, StallE, StallM  out  1 each  hold the named pipeline register.
REQ-012 SHALL have outputs FlushD, FlushE, FlushW  out  1 each  load a bubble (all controls 0) into the named register.
REQ-013 SHALL have outputs ForwardAE, ForwardBE  out  2 each  execute operand select.
REQ-014 SHALL have outputs StallCnt  out  CNT_WIDTH  stall-cycle count; MemErr  out  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE and MEM_WAIT.
REQ-016 IDLE: MemReqM=1 and MemReady=0 SHALL move to MEM_WAIT next edge; otherwise stay in IDLE.
REQ-017 MEM_WAIT: MemReady=1 SHALL return to IDLE next edge; WaitCnt reaching MEM_TIMEOUT SHALL set MemErr and return to IDLE.
REQ-018 memStall = MemReqM & ~MemReady & ~timeoutHit, combinational, in either state; while asserted StallF=StallD=StallE=StallM=1 and FlushW=1.
REQ-019 WaitCnt SHALL clear on entering MEM_WAIT and increment each MEM_WAIT cycle; timeoutHit = (state==MEM_WAIT and WaitCnt==MEM_TIMEOUT).
REQ-020 lwStall = ResultSrcE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D); SHALL give StallF=StallD=1, FlushE=1 for one cycle.
REQ-021 PCSrcE=1 SHALL give FlushD=1, FlushE=1, and SHALL force StallF=StallD=0 even if lwStall.
REQ-022 memStall SHALL take priority: while asserted FlushD=FlushE=0 and lwStall/PCSrcE effects deferred until release.
REQ-023 ForwardAE SHALL be 2'b10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 2'b01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 2'b00; ForwardBE identical using Rs2E.
REQ-024 StallCnt SHALL increment by 1 on each edge where any Stall* output is 1, saturating at all-ones.
REQ-025 MemErr SHALL remain 1 once set until reset.
REQ-026 Release: cycle MemReady rises, memStall SHALL deassert combinationally (zero added latency).

Reset
REQ-027 rst=1 SHALL asynchronously set state=IDLE, WaitCnt=0, StallCnt=0, MemErr=0.
REQ-028 While rst=1, Stall*=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=2'b00.
REQ-029 rst asserted in MEM_WAIT SHALL abort the wait with no MemErr; IDLE on release.

Structure
REQ-030 Package pipe_pkg SHALL hold the state enum (IDLE, MEM_WAIT) and forward encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
REQ-031 Forwarding logic SHALL be one combinational sub-module pipe_fwd, instantiated once per operand.

Verification
REQ-032 Load-use: ResultSrcE=1, RdE=5, Rs1D=5 -> one cycle StallF=StallD=FlushE=1, StallCnt +1.
REQ-033 Forwarding: RegWriteM=1, RdM=3; RegWriteW=1, RdW=3; Rs1E=3 -> ForwardAE=2'b10; RdM=0, RdW=3 -> 2'b01; all Rd=0 -> 2'b00.
REQ-034 Branch: PCSrcE=1 with lwStall true -> FlushD=FlushE=1, StallF=StallD=0.
REQ-035 Memory wait: MemReqM=1, MemReady low 4 cycles then high -> four cycles all Stall*=1, FlushW=1; IDLE after; StallCnt=4.
REQ-036 Timeout: MEM_TIMEOUT=8, MemReady held 0 -> MemErr=1 after 8 MEM_WAIT cycles, stalls release, MemErr stays 1.
REQ-037 Reset mid-wait: rst pulsed in MEM_WAIT cycle 2 -> state IDLE, StallCnt=0, MemErr=0, Flush*=1 during rst.
